// File: rtl/ones_mod_rr_ctrl_if.sv
// Handshake bundle between two word producers, the shared ones-count checker
// and the result consumer.
interface ones_mod_rr_ctrl_if #(
  parameter int WIDTH = 8
) ();
  localparam int OW = $clog2(WIDTH + 1);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_vld;
  logic             ser_bit;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic             res_hit;
  logic [OW-1:0]    res_ones;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, ser_vld, ser_bit,
           res_valid, res_id, res_hit, res_ones
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, ser_vld, ser_bit,
           res_valid, res_id, res_hit, res_ones
  );
endinterface

// File: rtl/ones_mod_rr_ctrl.sv
// Round-robin front end sharing one serial mod-MOD ones counter between two
// requesters; each word is shifted out MSB first and a tagged result reported.
module ones_mod_rr_ctrl #(
  parameter int WIDTH = 8,
  parameter int MOD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  ones_mod_rr_ctrl_if.slave bus
);
  localparam int OW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int MW = $clog2(MOD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [MW-1:0]    modcnt_q, modcnt_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             id_q, id_d;
  logic             last_q, last_d;

  logic grant1, hs0, hs1;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  always_comb begin
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    hs0    = ~rst & (state_q == S_IDLE) & bus.req0_valid & ~grant1;
    hs1    = ~rst & (state_q == S_IDLE) & grant1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      modcnt_q <= '0;
      ones_q   <= '0;
      idx_q    <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      modcnt_q <= modcnt_d;
      ones_q   <= ones_d;
      idx_q    <= idx_d;
      id_q     <= id_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    modcnt_d = modcnt_q;
    ones_d   = ones_q;
    idx_d    = idx_q;
    id_d     = id_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (hs0 | hs1) begin
          shift_d  = hs1 ? bus.req1_data : bus.req0_data;
          modcnt_d = '0;
          ones_d   = '0;
          idx_d    = '0;
          id_d     = hs1;
          last_d   = hs1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q << 1;
        if (shift_q[WIDTH-1]) begin
          if (ones_q < OW'(WIDTH)) ones_d = ones_q + 1'b1;
          modcnt_d = (modcnt_q == MW'(MOD - 1)) ? '0 : modcnt_q + 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(WIDTH - 1)) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result fields are forced to 0 outside REPORT so reset and idle read as 0.
  assign bus.req0_ready = hs0;
  assign bus.req1_ready = hs1;
  assign bus.ser_vld    = (state_q == S_SHIFT);
  assign bus.ser_bit    = (state_q == S_SHIFT) & shift_q[WIDTH-1];
  assign bus.res_valid  = (state_q == S_REPORT);
  assign bus.res_id     = (state_q == S_REPORT) & id_q;
  assign bus.res_hit    = (state_q == S_REPORT) & (modcnt_q == '0);
  assign bus.res_ones   = (state_q == S_REPORT) ? ones_q : '0;
endmodule
